alphabet_sched_gen: RTL and testbench

- Sequential, table-driven generalisation of the day/slot-to-alphabet lookup in the Digital VLSI scheduling path.
- Walks every (day, slot) pair from (1,0) to (DAYS, SLOTS-1) and emits one alphabet code per pair over a valid/ready stream.
- The group table is run-time programmable.
- Sits between the schedule controller (start/abort) and the display/encoder consumer.

---
 rtl/alphabet_sched_gen_if.sv | 28 ++
 rtl/alphabet_sched_gen.sv | 180 ++++++++++++++++++
 tb/tb_alphabet_sched_gen.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alphabet_sched_gen_if.sv
// rtl/alphabet_sched_gen_if.sv - output tuple stream (valid/ready) between sweep generator and consumer
interface alphabet_sched_gen_if #(
  parameter int D_W = 6,
  parameter int S_W = 3,
  parameter int A_W = 5
);
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] out_d;
  logic [S_W-1:0] out_s;
  logic [A_W-1:0] out_alpha;

  modport master (
    output out_valid,
    output out_d,
    output out_s,
    output out_alpha,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_d,
    input  out_s,
    input  out_alpha,
    output out_ready
  );
endinterface

// File: rtl/alphabet_sched_gen.sv
// rtl/alphabet_sched_gen.sv - sweeps (day, slot) pairs and streams a table-looked-up alphabet code per pair
// Define ALPHABET_LEGACY_TABLE_EN to make reset load the legacy group mapping instead of an all-zero table.
module alphabet_sched_gen #(
  parameter int D_W   = 6,
  parameter int S_W   = 3,
  parameter int A_W   = 5,
  parameter int N_GRP = 9,
  parameter int DAYS  = 13,
  parameter int SLOTS = 6,
  localparam int IDX_W = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [D_W-1:0]       cfg_dmax,
  input  logic [A_W-1:0]       cfg_code0,
  input  logic [A_W-1:0]       cfg_coden,
  alphabet_sched_gen_if.master out_if,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [D_W-1:0] LAST_D = D_W'(DAYS);
  localparam logic [S_W-1:0] LAST_S = S_W'(SLOTS - 1);

`ifdef ALPHABET_LEGACY_TABLE_EN
  if (N_GRP < 9) begin : g_legacy_chk
    $error("alphabet_sched_gen: legacy table needs N_GRP >= 9");
  end

  function automatic logic [D_W+2*A_W-1:0] legacy_entry(input int i);
    case (i)
      0:       return {D_W'(1),  A_W'(1), A_W'(1)};
      1:       return {D_W'(2),  A_W'(2), A_W'(2)};
      2:       return {D_W'(3),  A_W'(3), A_W'(3)};
      3:       return {D_W'(4),  A_W'(4), A_W'(4)};
      4:       return {D_W'(5),  A_W'(5), A_W'(5)};
      5:       return {D_W'(6),  A_W'(6), A_W'(6)};
      6:       return {D_W'(7),  A_W'(6), A_W'(6)};
      7:       return {D_W'(10), A_W'(7), A_W'(8)};
      8:       return {D_W'(13), A_W'(9), A_W'(10)};
      default: return '0;
    endcase
  endfunction
`endif

  logic [1:0]     state_q, state_d;
  logic [D_W-1:0] d_q, d_d;
  logic [S_W-1:0] s_q, s_d;
  logic [A_W-1:0] alpha_q, alpha_d;
  logic           ld;
  logic           xfer;
  logic           last;
  logic           hit;

  logic [D_W-1:0] dmax_q  [N_GRP];
  logic [D_W-1:0] dmax_d  [N_GRP];
  logic [A_W-1:0] code0_q [N_GRP];
  logic [A_W-1:0] code0_d [N_GRP];
  logic [A_W-1:0] coden_q [N_GRP];
  logic [A_W-1:0] coden_d [N_GRP];
  logic           tbl_we;

  assign out_if.out_valid = (state_q == ST_RUN);
  assign out_if.out_d     = d_q;
  assign out_if.out_s     = s_q;
  assign out_if.out_alpha = alpha_q;
  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);

  assign xfer = out_if.out_valid && out_if.out_ready;
  assign last = (d_q == LAST_D) && (s_q == LAST_S);

  // The write lands before a same-cycle start, so the lookup below sees the post-write table.
  always_comb begin
    tbl_we = (state_q == ST_IDLE) && cfg_we && (32'(cfg_idx) < 32'(N_GRP));
    for (int i = 0; i < N_GRP; i++) begin
      dmax_d[i]  = dmax_q[i];
      code0_d[i] = code0_q[i];
      coden_d[i] = coden_q[i];
      if (tbl_we && (cfg_idx == IDX_W'(i))) begin
        dmax_d[i]  = cfg_dmax;
        code0_d[i] = cfg_code0;
        coden_d[i] = cfg_coden;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    s_d     = s_q;
    ld      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          d_d     = D_W'(1);
          s_d     = '0;
          ld      = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            ld = 1'b1;
            if (s_q == LAST_S) begin
              s_d = '0;
              d_d = d_q + D_W'(1);
            end else begin
              s_d = s_q + S_W'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Lowest-index enabled entry whose day bound covers d wins.
  always_comb begin
    alpha_d = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_GRP; i++) begin
      if (!hit && (dmax_d[i] != '0) && (d_d <= dmax_d[i])) begin
        hit     = 1'b1;
        alpha_d = (s_d == '0) ? code0_d[i] : coden_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      s_q     <= '0;
      alpha_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld) begin
        d_q     <= d_d;
        s_q     <= s_d;
        alpha_q <= alpha_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_GRP; i++) begin
`ifdef ALPHABET_LEGACY_TABLE_EN
        {dmax_q[i], code0_q[i], coden_q[i]} <= legacy_entry(i);
`else
        dmax_q[i]  <= '0;
        code0_q[i] <= '0;
        coden_q[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_GRP; i++) begin
        dmax_q[i]  <= dmax_d[i];
        code0_q[i] <= code0_d[i];
        coden_q[i] <= coden_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alphabet_sched_gen.sv
// tb/tb_alphabet_sched_gen.sv - self-checking bench for alphabet_sched_gen
module tb_alphabet_sched_gen;
  localparam int D_W   = 6;
  localparam int S_W   = 3;
  localparam int A_W   = 5;
  localparam int N_GRP = 9;
  localparam int DAYS  = 13;
  localparam int SLOTS = 6;
  localparam int TOTAL = DAYS * SLOTS;
`ifdef ALPHABET_LEGACY_TABLE_EN
  localparam int RST_A80  = 7;
  localparam int RST_A135 = 10;
`else
  localparam int RST_A80  = 0;
  localparam int RST_A135 = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           cfg_we = 1'b0;
  logic [3:0]     cfg_idx = '0;
  logic [D_W-1:0] cfg_dmax = '0;
  logic [A_W-1:0] cfg_code0 = '0;
  logic [A_W-1:0] cfg_coden = '0;
  logic           busy;
  logic           done;

  alphabet_sched_gen_if #(.D_W(D_W), .S_W(S_W), .A_W(A_W)) oif ();

  alphabet_sched_gen #(
    .D_W(D_W), .S_W(S_W), .A_W(A_W), .N_GRP(N_GRP), .DAYS(DAYS), .SLOTS(SLOTS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_dmax(cfg_dmax),
    .cfg_code0(cfg_code0), .cfg_coden(cfg_coden),
    .out_if(oif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_dmax [N_GRP];
  int m_c0   [N_GRP];
  int m_cn   [N_GRP];
  bit exp_run, exp_done, nxt_done, prev_stall, mon_on, rdy_rand;
  int m_k, ed, es, h_d, h_s, h_a;

  int cap [16][8];
  int n_xfer, done_cnt, first_d, first_s;

  int lg_d [N_GRP] = '{1, 2, 3, 4, 5, 6, 7, 10, 13};
  int lg_0 [N_GRP] = '{1, 2, 3, 4, 5, 6, 6, 7, 9};
  int lg_n [N_GRP] = '{1, 2, 3, 4, 5, 6, 6, 8, 10};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_lookup(input int d, input int s);
    for (int i = 0; i < N_GRP; i++)
      if (m_dmax[i] != 0 && d <= m_dmax[i]) return (s == 0) ? m_c0[i] : m_cn[i];
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_GRP; i++) begin
`ifdef ALPHABET_LEGACY_TABLE_EN
      m_dmax[i] = lg_d[i]; m_c0[i] = lg_0[i]; m_cn[i] = lg_n[i];
`else
      m_dmax[i] = 0; m_c0[i] = 0; m_cn[i] = 0;
`endif
    end
    exp_run = 0; exp_done = 0; prev_stall = 0; m_k = 0;
  endtask

  // Expected tuple k of a sweep is simply (1 + k/SLOTS, k%SLOTS).
  always @(negedge clk) begin
    if (mon_on) begin
      chk("out_valid", oif.out_valid, exp_run);
      chk("busy", busy, exp_run);
      chk("done", done, exp_done);
      if (done) done_cnt++;
      if (exp_run && oif.out_valid) begin
        ed = 1 + m_k / SLOTS;
        es = m_k % SLOTS;
        chk("out_d", oif.out_d, ed);
        chk("out_s", oif.out_s, es);
        chk("out_alpha", oif.out_alpha, m_lookup(ed, es));
        if (prev_stall) begin
          chk("stall_d", oif.out_d, h_d);
          chk("stall_s", oif.out_s, h_s);
          chk("stall_alpha", oif.out_alpha, h_a);
        end
      end
      if (oif.out_valid && oif.out_ready && !abort) begin
        if (n_xfer == 0) begin first_d = oif.out_d; first_s = oif.out_s; end
        if (oif.out_d < 16) cap[oif.out_d][oif.out_s] = oif.out_alpha;
        n_xfer++;
      end
      prev_stall = exp_run && !oif.out_ready && !abort;
      h_d = oif.out_d; h_s = oif.out_s; h_a = oif.out_alpha;
      nxt_done = 0;
      if (exp_run) begin
        if (abort) exp_run = 0;
        else if (oif.out_ready) begin
          m_k++;
          if (m_k == TOTAL) begin exp_run = 0; nxt_done = 1; end
        end
      end else if (!exp_done) begin
        if (cfg_we && cfg_idx < N_GRP) begin
          m_dmax[cfg_idx] = cfg_dmax; m_c0[cfg_idx] = cfg_code0; m_cn[cfg_idx] = cfg_coden;
        end
        if (start) begin exp_run = 1; m_k = 0; end
      end
      exp_done = nxt_done;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) oif.out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic clear_stats();
    n_xfer = 0; done_cnt = 0; first_d = -1; first_s = -1;
    for (int d = 0; d < 16; d++) for (int s = 0; s < 8; s++) cap[d][s] = -1;
  endtask

  task automatic do_write(input int idx, input int dm, input int c0, input int cn, input bit st);
    @(posedge clk); #1;
    cfg_we = 1; cfg_idx = 4'(idx); cfg_dmax = D_W'(dm);
    cfg_code0 = A_W'(c0); cfg_coden = A_W'(cn); start = st;
    @(posedge clk); #1;
    cfg_we = 0; start = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((oif.out_valid || busy || done) && cyc < 600) begin
      @(posedge clk); #1; cyc++;
    end
    chk("sweep_timeout", int'(cyc < 600), 1);
  endtask

  task automatic check_full_sweep(input string tag);
    chk({tag, "_xfers"}, n_xfer, TOTAL);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_first_d"}, first_d, 1);
    chk({tag, "_first_s"}, first_s, 0);
  endtask

  initial begin
    int cyc;
    model_reset();
    rdy_rand = 0; mon_on = 0;
    oif.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", oif.out_valid, 0);
    chk("rst_d", oif.out_d, 0);
    chk("rst_s", oif.out_s, 0);
    chk("rst_alpha", oif.out_alpha, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    mon_on = 1;

    clear_stats(); do_start(); wait_idle();
    check_full_sweep("reset_table");
    chk("reset_table_8_0", cap[8][0], RST_A80);
    chk("reset_table_13_5", cap[13][5], RST_A135);

    for (int i = 1; i < N_GRP; i++) do_write(i, 0, 0, 0, 0);
    clear_stats(); do_write(0, 4, 3, 17, 1); wait_idle();
    check_full_sweep("idx0");
    chk("idx0_2_0", cap[2][0], 3);
    chk("idx0_4_5", cap[4][5], 17);
    chk("idx0_5_1", cap[5][1], 0);

    do_write(12, 13, 31, 31, 0);
    for (int i = 0; i < N_GRP; i++) do_write(i, lg_d[i], lg_0[i], lg_n[i], 0);
    chk("model_pin_7_3", m_lookup(7, 3), 6);
    chk("model_pin_13_5", m_lookup(13, 5), 10);
    clear_stats(); do_start(); wait_idle();
    check_full_sweep("legacy");
    chk("legacy_1_0", cap[1][0], 1);
    chk("legacy_7_3", cap[7][3], 6);
    chk("legacy_8_0", cap[8][0], 7);
    chk("legacy_9_4", cap[9][4], 8);
    chk("legacy_13_0", cap[13][0], 9);
    chk("legacy_13_5", cap[13][5], 10);

    clear_stats(); rdy_rand = 1; do_start(); wait_idle();
    rdy_rand = 0; oif.out_ready = 1;
    check_full_sweep("stall");
    chk("stall_7_3", cap[7][3], 6);
    chk("stall_9_4", cap[9][4], 8);
    chk("stall_13_5", cap[13][5], 10);

    clear_stats(); do_start();
    repeat (5) @(posedge clk);
    #1;
    do_write(8, 13, 31, 31, 1);
    wait_idle();
    check_full_sweep("run_write");
    chk("run_write_13_2", cap[13][2], 10);
    do_write(8, 13, 31, 31, 0);
    clear_stats(); do_start(); wait_idle();
    check_full_sweep("idle_write");
    chk("idle_write_13_2", cap[13][2], 31);
    chk("idle_write_12_0", cap[12][0], 31);
    chk("idle_write_10_0", cap[10][0], 7);

    clear_stats(); do_start();
    cyc = 0;
    while (m_k != 20 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("abort_reach_timeout", int'(cyc < 200), 1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_valid", oif.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_xfers", n_xfer, 20);
    chk("abort_done_pulses", done_cnt, 0);
    clear_stats(); do_start(); wait_idle();
    check_full_sweep("after_abort");

    clear_stats(); do_start();
    repeat (30) @(posedge clk);
    #2;
    mon_on = 0;
    rst = 1;
    #1;
    chk("async_rst_valid", oif.out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    mon_on = 1;
    clear_stats(); do_start(); wait_idle();
    check_full_sweep("post_rst");
    chk("post_rst_8_0", cap[8][0], RST_A80);
    chk("post_rst_13_5", cap[13][5], RST_A135);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
